multiplier_feeder: RTL and testbench
====================================

// Module: multiplier_feeder
// PURPOSE
//  Upstream/downstream wrapper for the sequential Multiplier. Buffers operand pairs from a valid/ready
//  producer in a small FIFO and issues them one at a time to the Multiplier (in_a/in_b/in_vld). It
//  captures each product when the Multiplier reports res_rdy and presents it on a valid/ready output.
//  Products leave in issue order. There is never more than one multiply in flight.
// PARAMETERS
//  WIDTH      8   operand width; product width is 2*WIDTH
//  DEPTH      4   operand FIFO entries (power of two, >=2)
//  CNT_WIDTH  16  width of completed-result counter done_cnt
// PORTS
//  clk       in   1         clock; all logic on posedge
//  rst       in   1         synchronous, active-high reset
//  op_a      in   WIDTH     upstream operand A
//  op_b      in   WIDTH     upstream operand B
//  op_vld    in   1         upstream pair valid
//  op_rdy    out  1         FIFO can accept; transfer when op_vld && op_rdy
//  mul_a     out  WIDTH     to Multiplier in_a
//  mul_b     out  WIDTH     to Multiplier in_b
//  mul_vld   out  1         to Multiplier in_vld; single-cycle start pulse
//  mul_res   in   2*WIDTH   from Multiplier res
//  mul_rdy   in   1         from Multiplier res_rdy (high = idle, res holds last product)
//  out_res   out  2*WIDTH   product to downstream
//  out_vld   out  1         out_res valid; held until out_rdy
//  out_rdy   in   1         downstream accepts; transfer when out_vld && out_rdy
//  done_cnt  out  CNT_WIDTH count of products delivered downstream; wraps modulo 2**CNT_WIDTH
// BEHAVIOUR
//  Reset (rst=1 at posedge)
//   - FIFO emptied; state=IDLE; mul_vld=0; mul_a=mul_b=0; out_vld=0; out_res=0; done_cnt=0.
//   - op_rdy=0 while rst=1. From the first cycle after reset, op_rdy=!full.
//  FIFO
//   - Push when op_vld && op_rdy. Pop only on issue. No bypass: a pair pushed in cycle N can issue at N+1 at the earliest.
//   - Push and pop in the same cycle are both honoured; occupancy is unchanged.
//   - When full, op_rdy=0 and op_a/op_b are ignored. Pointers wrap modulo DEPTH.
//  FSM (registered): IDLE -> ISSUE -> WAIT_LO -> WAIT_HI -> IDLE
//   - IDLE: go to ISSUE when FIFO non-empty && mul_rdy && !out_vld.
//   - ISSUE: exactly 1 cycle. mul_vld=1; mul_a/mul_b = FIFO head; pop the head. mul_a/mul_b hold
//     that value until the next issue.
//   - WAIT_LO: wait for mul_rdy=0; this hides the Multiplier's start latency. Stay while mul_rdy=1.
//   - WAIT_HI: on the first cycle with mul_rdy=1, register out_res<=mul_res, set out_vld=1, go to IDLE.
//  Output: out_vld clears on out_vld && out_rdy, and done_cnt increments in that same cycle.
//   - No new issue while out_vld=1. As a result, latency from push to out_vld is at least
//     Multiplier latency + 3 cycles.
//  Arithmetic: none. out_res equals mul_res bit-for-bit (full 2*WIDTH product, no truncation).
//  Reset mid-operation: FSM returns to IDLE and the FIFO is flushed. A Multiplier result that completes
//   after reset is discarded (out_vld stays 0).
//  mul_vld is never asserted in two consecutive cycles, and never while mul_rdy=0.
// STRUCTURE
//  - multiplier_pkg: WIDTH/DEPTH default localparams and the typedef enum feeder_state_t
//    {IDLE, ISSUE, WAIT_LO, WAIT_HI}.
//  - One sub-module, operand_fifo (DEPTH x 2*WIDTH, push/pop/full/empty). The FSM, result
//    register and counter sit in the top level.
// TESTING (bench instantiates a real Multiplier; out_rdy=1 unless noted)
//  1 rst=1 for 2 cycles -> out_vld=0, mul_vld=0, op_rdy=0; after release op_rdy=1, done_cnt=0.
//  2 push (3,5) -> one mul_vld pulse with mul_a=3, mul_b=5; later out_res=15, out_vld=1; done_cnt=1.
//  3 out_rdy=0, push (7,9),(2,4) -> out_res=63 held, no second mul_vld; set out_rdy=1 -> 63 then 8, in order.
//  4 out_rdy=0, push 5 pairs back-to-back -> op_rdy drops after the 5th accept (4 queued + 1 in flight);
//    then drain -> 5 correct products in order.
//  5 push (255,255) -> out_res=16'hFE01; push (0,200) -> out_res=0.
//  6 assert rst during WAIT_HI with 2 pairs queued -> no out_vld afterwards; FIFO empty; next push (6,6) -> 36.

Source files
------------

// File: rtl/multiplier_pkg.sv
// rtl/multiplier_pkg.sv - shared defaults and FSM state type for the multiplier feeder
package multiplier_pkg;
   localparam int DEF_WIDTH     = 8;
   localparam int DEF_DEPTH     = 4;
   localparam int DEF_CNT_WIDTH = 16;

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT_LO, WAIT_HI} feeder_state_t;
endpackage

// File: rtl/operand_fifo.sv
// rtl/operand_fifo.sv - DEPTH-entry operand FIFO, no bypass; push and pop in one cycle both honoured
module operand_fifo #(
   parameter int DW    = 16,
   parameter int DEPTH = 4
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          push,
   input  logic [DW-1:0] wdata,
   input  logic          pop,
   output logic [DW-1:0] rdata,
   output logic          full,
   output logic          empty
);
   localparam int AW = $clog2(DEPTH);

   logic [DW-1:0] mem_q [DEPTH];
   logic [DW-1:0] mem_d [DEPTH];
   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [AW:0]   count_q, count_d;
   logic          do_push, do_pop;

   assign full    = (count_q == (AW+1)'(DEPTH));
   assign empty   = (count_q == '0);
   assign rdata   = mem_q[rd_ptr_q];
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;

   // Pointers are AW bits wide, so they wrap modulo DEPTH on their own.
   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (do_push) begin
         mem_d[wr_ptr_q] = wdata;
         wr_ptr_d        = wr_ptr_q + 1'b1;
      end
      if (do_pop) begin
         rd_ptr_d = rd_ptr_q + 1'b1;
      end
      case ({do_push, do_pop})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   always_ff @(posedge clk) begin
      mem_q <= mem_d;
   end
endmodule

// File: rtl/multiplier_feeder.sv
// rtl/multiplier_feeder.sv - queues operand pairs, issues them one at a time to a sequential multiplier
module multiplier_feeder
   import multiplier_pkg::*;
#(
   parameter int WIDTH     = DEF_WIDTH,
   parameter int DEPTH     = DEF_DEPTH,
   parameter int CNT_WIDTH = DEF_CNT_WIDTH
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [WIDTH-1:0]     op_a,
   input  logic [WIDTH-1:0]     op_b,
   input  logic                 op_vld,
   output logic                 op_rdy,
   output logic [WIDTH-1:0]     mul_a,
   output logic [WIDTH-1:0]     mul_b,
   output logic                 mul_vld,
   input  logic [2*WIDTH-1:0]   mul_res,
   input  logic                 mul_rdy,
   output logic [2*WIDTH-1:0]   out_res,
   output logic                 out_vld,
   input  logic                 out_rdy,
   output logic [CNT_WIDTH-1:0] done_cnt
);
   feeder_state_t          state_q, state_d;
   logic [WIDTH-1:0]       mul_a_q, mul_a_d;
   logic [WIDTH-1:0]       mul_b_q, mul_b_d;
   logic                   mul_vld_q, mul_vld_d;
   logic [2*WIDTH-1:0]     out_res_q, out_res_d;
   logic                   out_vld_q, out_vld_d;
   logic [CNT_WIDTH-1:0]   done_cnt_q, done_cnt_d;

   logic                   fifo_push, fifo_pop, fifo_full, fifo_empty;
   logic [2*WIDTH-1:0]     fifo_head;

   assign op_rdy    = !rst && !fifo_full;
   assign fifo_push = op_vld && op_rdy;

   operand_fifo #(
      .DW    (2*WIDTH),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (fifo_push),
      .wdata ({op_a, op_b}),
      .pop   (fifo_pop),
      .rdata (fifo_head),
      .full  (fifo_full),
      .empty (fifo_empty)
   );

   always_comb begin
      state_d    = state_q;
      mul_a_d    = mul_a_q;
      mul_b_d    = mul_b_q;
      mul_vld_d  = 1'b0;
      out_res_d  = out_res_q;
      out_vld_d  = out_vld_q;
      done_cnt_d = done_cnt_q;
      fifo_pop   = 1'b0;

      if (out_vld_q && out_rdy) begin
         out_vld_d  = 1'b0;
         done_cnt_d = done_cnt_q + CNT_WIDTH'(1);
      end

      // Holding off while out_vld is set keeps at most one product outstanding.
      case (state_q)
         IDLE: begin
            if (!fifo_empty && mul_rdy && !out_vld_q) begin
               state_d            = ISSUE;
               mul_vld_d          = 1'b1;
               {mul_a_d, mul_b_d} = fifo_head;
               fifo_pop           = 1'b1;
            end
         end
         ISSUE:   state_d = WAIT_LO;
         WAIT_LO: if (!mul_rdy) state_d = WAIT_HI;
         WAIT_HI: begin
            if (mul_rdy) begin
               out_res_d = mul_res;
               out_vld_d = 1'b1;
               state_d   = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         mul_a_q    <= '0;
         mul_b_q    <= '0;
         mul_vld_q  <= 1'b0;
         out_res_q  <= '0;
         out_vld_q  <= 1'b0;
         done_cnt_q <= '0;
      end else begin
         state_q    <= state_d;
         mul_a_q    <= mul_a_d;
         mul_b_q    <= mul_b_d;
         mul_vld_q  <= mul_vld_d;
         out_res_q  <= out_res_d;
         out_vld_q  <= out_vld_d;
         done_cnt_q <= done_cnt_d;
      end
   end

   assign mul_a    = mul_a_q;
   assign mul_b    = mul_b_q;
   assign mul_vld  = mul_vld_q;
   assign out_res  = out_res_q;
   assign out_vld  = out_vld_q;
   assign done_cnt = done_cnt_q;
endmodule

// File: tb/tb_multiplier_feeder.sv
// tb/tb_multiplier_feeder.sv - directed bench for multiplier_feeder with a behavioural sequential multiplier
module tb_multiplier_feeder;
   import multiplier_pkg::*;

   localparam int W       = 8;
   localparam int CW      = 16;
   localparam int MUL_LAT = 4;

   logic            clk = 1'b0;
   logic            rst;
   logic [W-1:0]    op_a, op_b;
   logic            op_vld;
   logic            op_rdy;
   logic [W-1:0]    mul_a, mul_b;
   logic            mul_vld;
   logic [2*W-1:0]  mul_res = '0;
   logic            mul_rdy = 1'b1;
   logic [2*W-1:0]  out_res;
   logic            out_vld;
   logic            out_rdy;
   logic [CW-1:0]   done_cnt;

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   multiplier_feeder #(.WIDTH(W), .DEPTH(4), .CNT_WIDTH(CW)) dut (
      .clk      (clk),
      .rst      (rst),
      .op_a     (op_a),
      .op_b     (op_b),
      .op_vld   (op_vld),
      .op_rdy   (op_rdy),
      .mul_a    (mul_a),
      .mul_b    (mul_b),
      .mul_vld  (mul_vld),
      .mul_res  (mul_res),
      .mul_rdy  (mul_rdy),
      .out_res  (out_res),
      .out_vld  (out_vld),
      .out_rdy  (out_rdy),
      .done_cnt (done_cnt)
   );

   // Sequential multiplier: not tied to rst, so a product can land after a feeder reset.
   logic [W-1:0] m_a = '0, m_b = '0;
   int           m_cnt = 0;
   always @(posedge clk) begin
      if (mul_vld) begin
         m_a     <= mul_a;
         m_b     <= mul_b;
         m_cnt   <= MUL_LAT;
         mul_rdy <= 1'b0;
      end else if (m_cnt > 0) begin
         m_cnt <= m_cnt - 1;
         if (m_cnt == 1) begin
            mul_res <= m_a * m_b;
            mul_rdy <= 1'b1;
         end
      end
   end

   logic [2*W-1:0] got[$];
   int             pulses = 0;
   int             viol = 0;
   logic           prev_vld = 1'b0;
   logic [W-1:0]   last_a = '0, last_b = '0;

   always @(negedge clk) begin
      if (!rst && out_vld && out_rdy) got.push_back(out_res);
      if (mul_vld) begin
         pulses++;
         last_a = mul_a;
         last_b = mul_b;
         if (prev_vld || !mul_rdy) viol++;
      end
      prev_vld = mul_vld;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic cycles(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic push(input logic [W-1:0] a, input logic [W-1:0] b);
      int t;
      op_a   = a;
      op_b   = b;
      op_vld = 1'b1;
      t      = 0;
      @(negedge clk);
      while (!op_rdy && t < 300) begin
         @(negedge clk);
         t++;
      end
      if (!op_rdy) chk("push_accept", {31'd0, op_rdy}, 32'd1);
      @(posedge clk);
      #1;
      op_vld = 1'b0;
   endtask

   task automatic wait_results(input int n);
      int t;
      t = 0;
      while (got.size() < n && t < 500) begin
         @(posedge clk);
         t++;
      end
      #1;
      chk("result_count", got.size(), n);
   endtask

   task automatic wait_out_vld();
      int t;
      t = 0;
      while (!out_vld && t < 500) begin
         @(negedge clk);
         t++;
      end
      chk("out_vld_seen", {31'd0, out_vld}, 32'd1);
   endtask

   int base, p0, n_before;

   initial begin
      rst    = 1'b1;
      op_a   = '0;
      op_b   = '0;
      op_vld = 1'b0;
      out_rdy = 1'b1;

      // 1: reset
      @(posedge clk);
      @(negedge clk);
      chk("rst_out_vld", {31'd0, out_vld}, 32'd0);
      chk("rst_mul_vld", {31'd0, mul_vld}, 32'd0);
      chk("rst_op_rdy",  {31'd0, op_rdy},  32'd0);
      @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      chk("post_rst_op_rdy", {31'd0, op_rdy}, 32'd1);
      chk("post_rst_done",   {16'd0, done_cnt}, 32'd0);
      chk("post_rst_out_res", {16'd0, out_res}, 32'd0);
      cycles(1);

      // 2: single product
      p0 = pulses;
      push(8'd3, 8'd5);
      wait_results(1);
      chk("t2_res",    {16'd0, got[0]}, 32'd15);
      chk("t2_pulses", pulses - p0, 1);
      chk("t2_mul_a",  {24'd0, last_a}, 32'd3);
      chk("t2_mul_b",  {24'd0, last_b}, 32'd5);
      cycles(2);
      chk("t2_done",   {16'd0, done_cnt}, 32'd1);

      // 3: backpressure holds the product and blocks the next issue
      out_rdy = 1'b0;
      p0 = pulses;
      base = got.size();
      push(8'd7, 8'd9);
      push(8'd2, 8'd4);
      wait_out_vld();
      cycles(20);
      chk("t3_held_res", {16'd0, out_res}, 32'd63);
      chk("t3_held_vld", {31'd0, out_vld}, 32'd1);
      chk("t3_pulses",   pulses - p0, 1);
      out_rdy = 1'b1;
      wait_results(base + 2);
      chk("t3_res0", {16'd0, got[base]},     32'd63);
      chk("t3_res1", {16'd0, got[base + 1]}, 32'd8);
      cycles(2);
      chk("t3_done", {16'd0, done_cnt}, 32'd3);

      // 4: fill the FIFO: four queued plus one in flight
      out_rdy = 1'b0;
      base = got.size();
      push(8'd1,   8'd2);
      push(8'd3,   8'd4);
      push(8'd10,  8'd11);
      push(8'd12,  8'd13);
      push(8'd100, 8'd3);
      @(negedge clk);
      chk("t4_full_op_rdy", {31'd0, op_rdy}, 32'd0);
      cycles(10);
      chk("t4_still_full", {31'd0, op_rdy}, 32'd0);
      out_rdy = 1'b1;
      wait_results(base + 5);
      chk("t4_res0", {16'd0, got[base]},     32'd2);
      chk("t4_res1", {16'd0, got[base + 1]}, 32'd12);
      chk("t4_res2", {16'd0, got[base + 2]}, 32'd110);
      chk("t4_res3", {16'd0, got[base + 3]}, 32'd156);
      chk("t4_res4", {16'd0, got[base + 4]}, 32'd300);
      cycles(2);
      chk("t4_done", {16'd0, done_cnt}, 32'd8);

      // 5: operand extremes
      base = got.size();
      push(8'd255, 8'd255);
      push(8'd0,   8'd200);
      wait_results(base + 2);
      chk("t5_max",  {16'd0, got[base]},     32'h0000FE01);
      chk("t5_zero", {16'd0, got[base + 1]}, 32'd0);
      cycles(2);
      chk("t5_done", {16'd0, done_cnt}, 32'd10);

      // 6: reset while waiting on the multiplier with two pairs queued
      push(8'd9, 8'd9);
      push(8'd8, 8'd8);
      push(8'd7, 8'd7);
      begin
         int t;
         t = 0;
         while (dut.state_q != WAIT_HI && t < 100) begin
            @(negedge clk);
            t++;
         end
      end
      chk("t6_reached_wait_hi", {30'd0, dut.state_q}, {30'd0, WAIT_HI});
      @(posedge clk);
      #1 rst = 1'b1;
      @(posedge clk);
      #1 rst = 1'b0;
      n_before = got.size();
      p0 = pulses;
      cycles(20);
      chk("t6_no_out_vld",  {31'd0, out_vld}, 32'd0);
      chk("t6_no_results",  got.size(), n_before);
      chk("t6_no_issue",    pulses - p0, 0);
      chk("t6_fifo_empty",  {31'd0, dut.u_fifo.empty}, 32'd1);
      chk("t6_done_rst",    {16'd0, done_cnt}, 32'd0);
      push(8'd6, 8'd6);
      wait_results(n_before + 1);
      chk("t6_res", {16'd0, got[n_before]}, 32'd36);
      cycles(2);
      chk("t6_done", {16'd0, done_cnt}, 32'd1);

      chk("mul_vld_rules", viol, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
